// File: rtl/pcpi_sha_ctrl_if.sv
// PCPI bus bundle between a picorv32-style core (master) and a coprocessor (slave).
// Clock and reset stay outside the bundle as plain ports.
interface pcpi_sha_ctrl_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_sha_ctrl.sv
// Multi-cycle PCPI coprocessor for the four SHA-256 sigma functions: one shared
// rotate/shift unit feeds an XOR accumulator over three terms (4-cycle latency).
module pcpi_sha_ctrl #(
  parameter logic [6:0] OPCODE             = 7'b0001011,
  parameter bit         ENABLE_SMALL_SIGMA = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  pcpi_sha_ctrl_if.slave pcpi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] operand_q, operand_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rd_q, rd_d;
  logic        wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        wr_q, wr_d;

  // ---------------------------------------------------------------- decode
  logic [2:0] funct3;
  logic       match;
  logic       unused_bits;

  assign funct3      = pcpi.pcpi_insn[14:12];
  assign unused_bits = ^{pcpi.pcpi_rs2, pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  always_comb begin
    match = (pcpi.pcpi_insn[6:0] == OPCODE) && (pcpi.pcpi_insn[31:25] == 7'd0) &&
            ((funct3 == 3'b000) || (funct3 == 3'b001) ||
             (ENABLE_SMALL_SIGMA && ((funct3 == 3'b010) || (funct3 == 3'b011))));
  end

  // ------------------------------------------------- shared rotate/shift unit
  logic [1:0]  term_idx;
  logic [4:0]  shamt;
  logic        is_shr;
  logic [31:0] shr_val;
  logic [31:0] term;

  always_comb begin
    case (state_q)
      S_T0:    term_idx = 2'd0;
      S_T1:    term_idx = 2'd1;
      default: term_idx = 2'd2;
    endcase
  end

  // Shift amount and mode for each {op, term}; only term 2 of the small sigmas is a plain shift.
  always_comb begin
    is_shr = 1'b0;
    shamt  = 5'd0;
    case ({op_q, term_idx})
      4'b00_00: shamt = 5'd2;
      4'b00_01: shamt = 5'd13;
      4'b00_10: shamt = 5'd22;
      4'b01_00: shamt = 5'd6;
      4'b01_01: shamt = 5'd11;
      4'b01_10: shamt = 5'd25;
      4'b10_00: shamt = 5'd7;
      4'b10_01: shamt = 5'd18;
      4'b10_10: begin shamt = 5'd3;  is_shr = 1'b1; end
      4'b11_00: shamt = 5'd17;
      4'b11_01: shamt = 5'd19;
      4'b11_10: begin shamt = 5'd10; is_shr = 1'b1; end
      default:  shamt = 5'd0;
    endcase
  end

  assign shr_val = operand_q >> shamt;
  assign term    = is_shr ? shr_val
                          : (shr_val | (operand_q << (6'd32 - {1'b0, shamt})));

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pcpi.pcpi_valid && match) state_d = S_T0;
      S_T0:   state_d = pcpi.pcpi_valid ? S_T1   : S_IDLE;
      S_T1:   state_d = pcpi.pcpi_valid ? S_T2   : S_IDLE;
      S_T2:   state_d = pcpi.pcpi_valid ? S_DONE : S_IDLE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------- datapath and outputs
  // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    operand_d = operand_q;
    op_d      = op_q;
    acc_d     = acc_q;
    wait_d    = wait_q;
    rd_d      = 32'd0;
    ready_d   = 1'b0;
    wr_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pcpi.pcpi_valid && match) begin
          operand_d = pcpi.pcpi_rs1;
          op_d      = funct3[1:0];
          wait_d    = 1'b1;
        end
      end
      S_T0, S_T1, S_T2: begin
        if (!pcpi.pcpi_valid) begin
          wait_d = 1'b0;
          acc_d  = 32'd0;
        end else if (state_q == S_T0) begin
          acc_d = term;
        end else if (state_q == S_T1) begin
          acc_d = acc_q ^ term;
        end else begin
          rd_d    = acc_q ^ term;
          wr_d    = 1'b1;
          ready_d = 1'b1;
          wait_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: reset is synchronous and sampled at the edge; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      operand_q <= 32'd0;
      op_q      <= 2'd0;
      acc_q     <= 32'd0;
      rd_q      <= 32'd0;
      wait_q    <= 1'b0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      rd_q      <= rd_d;
      wait_q    <= wait_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
    end
  end

  assign pcpi.pcpi_wait  = wait_q;
  assign pcpi.pcpi_ready = ready_q;
  assign pcpi.pcpi_wr    = wr_q;
  assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_sha_ctrl.sv
// Directed bench for pcpi_sha_ctrl: vector table for the four sigma ops plus
// hand-written sequences for decode rejection, abort, reset and back-to-back issue.
module tb_pcpi_sha_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pcpi_sha_ctrl_if bus ();
  pcpi_sha_ctrl_if bus2 ();

  pcpi_sha_ctrl #(.OPCODE(7'b0001011), .ENABLE_SMALL_SIGMA(1'b1)) dut (
    .clk(clk), .resetn(resetn), .pcpi(bus)
  );

  pcpi_sha_ctrl #(.OPCODE(7'b0001011), .ENABLE_SMALL_SIGMA(1'b0)) dut_big_only (
    .clk(clk), .resetn(resetn), .pcpi(bus2)
  );

  assign bus2.pcpi_valid = bus.pcpi_valid;
  assign bus2.pcpi_insn  = bus.pcpi_insn;
  assign bus2.pcpi_rs1   = bus.pcpi_rs1;
  assign bus2.pcpi_rs2   = bus.pcpi_rs2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] x;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd0, 5'd1, f3, 5'd2, opc};
  endfunction

  task automatic idle_bus();
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = 32'd0;
    bus.pcpi_rs1   = 32'd0;
    bus.pcpi_rs2   = 32'd0;
  endtask

  // Issue one instruction and check latency, wait profile, result and one-cycle pulse.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] x,
                        input logic [31:0] exp, input bit perturb);
    logic [3:0]  wait_seen = 4'd0;
    int          ready_at  = -1;
    logic [31:0] rd_at     = 32'd0;
    logic        wr_at     = 1'b0;
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk(7'd0, f3, 7'b0001011);
    bus.pcpi_rs1   = x;
    bus.pcpi_rs2   = 32'hDEAD_BEEF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (perturb && k == 1) begin
        bus.pcpi_rs1  = 32'hFFFF_FFFF;
        bus.pcpi_insn = mk(7'd0, 3'b011, 7'b0001011);
      end
      if (k <= 4) wait_seen[k-1] = bus.pcpi_wait;
      if (bus.pcpi_ready && ready_at < 0) begin
        ready_at = k;
        rd_at    = bus.pcpi_rd;
        wr_at    = bus.pcpi_wr;
        bus.pcpi_valid = 1'b0;
      end else if (ready_at > 0 && k == ready_at + 1) begin
        check({name, " pulse end"}, {30'd0, bus.pcpi_ready, bus.pcpi_wr}, 32'd0);
        check({name, " rd cleared"}, bus.pcpi_rd, 32'd0);
      end
    end
    idle_bus();
    check({name, " latency"}, ready_at, 32'd4);
    check({name, " wait profile"}, {28'd0, wait_seen}, 32'h7);
    check({name, " wr"}, {31'd0, wr_at}, 32'd1);
    check({name, " rd"}, rd_at, exp);
  endtask

  // Hold an instruction for 20 cycles and require no handshake activity at all.
  task automatic no_ack(input string name, input logic [31:0] insn, input bit use_big_only);
    logic seen = 1'b0;
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = 32'h1;
    repeat (20) begin
      tick();
      if (use_big_only) seen |= bus2.pcpi_wait | bus2.pcpi_ready | bus2.pcpi_wr;
      else              seen |= bus.pcpi_wait | bus.pcpi_ready | bus.pcpi_wr;
    end
    idle_bus();
    repeat (3) tick();
    check({name, " no ack"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r1, r2;
    logic [31:0] rd1, rd2;

    vecs[0] = '{3'b000, 32'h0000_0001, 32'h4008_0400};
    vecs[1] = '{3'b001, 32'h0000_0001, 32'h0420_0080};
    vecs[2] = '{3'b010, 32'h0000_0001, 32'h0200_4000};
    vecs[3] = '{3'b011, 32'h0000_0001, 32'h0000_A000};
    vecs[4] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{3'b010, 32'hFFFF_FFFF, 32'h1FFF_FFFF};
    vecs[6] = '{3'b011, 32'hFFFF_FFFF, 32'h003F_FFFF};
    vecs[7] = '{3'b000, 32'h8000_0000, 32'h2004_0200};
    vecs[8] = '{3'b001, 32'h8000_0000, 32'h0210_0040};
    vecs[9] = '{3'b010, 32'h8000_0000, 32'h1100_2000};

    // Reset values
    idle_bus();
    resetn = 1'b0;
    tick();
    tick();
    check("reset wait",  {31'd0, bus.pcpi_wait},  32'd0);
    check("reset ready", {31'd0, bus.pcpi_ready}, 32'd0);
    check("reset wr",    {31'd0, bus.pcpi_wr},    32'd0);
    check("reset rd",    bus.pcpi_rd,             32'd0);
    resetn = 1'b1;
    tick();
    check("idle after reset", {31'd0, bus.pcpi_wait | bus.pcpi_ready}, 32'd0);

    // Operation vectors
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].x, vecs[i].exp, 1'b0);

    // Unclaimed encodings
    no_ack("opcode 0110011", mk(7'd0, 3'b000, 7'b0110011), 1'b0);
    no_ack("funct7 0000001", mk(7'b0000001, 3'b000, 7'b0001011), 1'b0);
    no_ack("funct3 100",     mk(7'd0, 3'b100, 7'b0001011), 1'b0);
    no_ack("small sigma disabled", mk(7'd0, 3'b010, 7'b0001011), 1'b1);

    // Abort: drop valid while in T1
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk(7'd0, 3'b000, 7'b0001011);
    bus.pcpi_rs1   = 32'h1;
    tick();
    tick();
    bus.pcpi_valid = 1'b0;
    tick();
    check("abort wait low", {31'd0, bus.pcpi_wait}, 32'd0);
    begin
      logic seen_ready = 1'b0;
      repeat (6) begin
        seen_ready |= bus.pcpi_ready;
        tick();
      end
      check("abort no ready", {31'd0, seen_ready}, 32'd0);
    end
    idle_bus();
    run_op("after abort Sigma1", 3'b001, 32'h1, 32'h0420_0080, 1'b0);

    // Reset while in T2
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk(7'd0, 3'b001, 7'b0001011);
    bus.pcpi_rs1   = 32'h1;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("reset in T2 ctl", {29'd0, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}, 32'd0);
    check("reset in T2 rd",  bus.pcpi_rd, 32'd0);
    resetn = 1'b1;
    idle_bus();
    tick();
    tick();
    check("after reset quiet", {31'd0, bus.pcpi_ready | bus.pcpi_wait}, 32'd0);

    // Operand stability: rs1 and insn change during T0..T2
    run_op("operand stable", 3'b000, 32'h1, 32'h4008_0400, 1'b1);

    // Back-to-back: valid held through DONE and the next acceptance
    r1 = -1; r2 = -1; rd1 = 32'd0; rd2 = 32'd0;
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk(7'd0, 3'b000, 7'b0001011);
    bus.pcpi_rs1   = 32'h1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.pcpi_ready) begin
        if (r1 < 0) begin r1 = k; rd1 = bus.pcpi_rd; end
        else if (r2 < 0) begin r2 = k; rd2 = bus.pcpi_rd; end
      end
    end
    idle_bus();
    repeat (6) tick();
    check("b2b first ready",  r1,  32'd4);
    check("b2b second ready", r2,  32'd9);
    check("b2b first rd",     rd1, 32'h4008_0400);
    check("b2b second rd",    rd2, 32'h4008_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpi_sha_ctrl.md
Name: pcpi_sha_ctrl

Overview:
- Multi-cycle PCPI coprocessor controller that computes all four SHA-256 sigma functions with one shared rotate/shift unit and one XOR accumulator.
- Sits on the picorv32 PCPI bus beside, or in place of, the single-cycle Sigma0 unit.
- Sequences three terms per instruction through an FSM and drives the pcpi_wait/pcpi_ready handshake.
- Trades 4-cycle latency for a single shifter instead of three parallel rotators.

Parameters:
- OPCODE, 7'b0001011, custom opcode claimed (CUSTOM_0).
- ENABLE_SMALL_SIGMA, 1, when 0 the funct3 010/011 operations are not claimed.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- resetn  input  1  reset, synchronous and active-low.
- pcpi_valid  input  1  core presents an instruction; held high until pcpi_ready or abort.
- pcpi_insn  input  32  instruction word.
- pcpi_rs1  input  32  source operand x.
- pcpi_rs2  input  32  unused; ignored.
- pcpi_wr  output  1  result write enable; high only with pcpi_ready.
- pcpi_rd  output  32  result; 0 whenever pcpi_ready is low.
- pcpi_wait  output  1  busy indication to core.
- pcpi_ready  output  1  one-cycle completion pulse.

Behaviour:
- Decode: match = insn[6:0]==OPCODE && insn[31:25]==0 && funct3 in {000,001} or, when ENABLE_SMALL_SIGMA=1, in {010,011}. Non-matching instructions are never acknowledged: wait, ready and wr all stay 0, so the core traps.
- Operations, each listed as term0, term1, term2:
  - 000 Sigma0: ROTR2, ROTR13, ROTR22.
  - 001 Sigma1: ROTR6, ROTR11, ROTR25.
  - 010 sigma0: ROTR7, ROTR18, SHR3.
  - 011 sigma1: ROTR17, ROTR19, SHR10.
- Shared unit: ROTR(x,n) = (x>>n)|(x<<(32-n)); SHR(x,n) = x>>n, zero fill. Amount and mode come from a table indexed by {op,term}. All values are 32-bit and all excess bits are discarded.
- FSM states: IDLE, T0, T1, T2, DONE. State and all outputs are registered.
- IDLE:
  - On valid && match, latch rs1 into the operand reg and funct3 into the op reg, set wait<=1, go to T0.
  - Otherwise stay in IDLE.
- T0: acc<=term0; go to T1.
- T1: acc<=acc^term1; go to T2.
- T2:
  - Result = acc^term2.
  - Set rd<=result, wr<=1, ready<=1, wait<=0; go to DONE.
- DONE:
  - Outputs visible for exactly one cycle.
  - Next edge clears ready, wr and rd to 0 and returns to IDLE.
  - Valid is ignored in DONE; this is a one-cycle guard against re-triggering on a stale valid.
- Timing: acceptance edge E; wait high in cycles E+1..E+3; ready/wr/rd valid in cycle E+4. Latency is fixed at 4 cycles, well inside the core's 16-cycle wait deadline.
- The operand is captured at E. Changes to rs1 or insn during T0..T2 do not affect the result.
- Abort: if pcpi_valid is low at any edge in T0..T2, go to IDLE, clear wait and acc, and issue no ready.
- Back-to-back: a new valid && match in IDLE immediately after DONE is accepted normally. Minimum spacing is 5 cycles per instruction.
- Reset: resetn low at an edge forces IDLE and clears wait, ready, wr, rd, acc and the operand/op regs to 0. This holds in any state, including mid-operation and DONE, and takes priority over everything else.
- No combinational path exists from inputs to outputs.

Test Plan:
- Reset values: hold resetn=0 for 2 cycles -> wait, ready, wr=0 and rd=0x00000000; release -> FSM in IDLE.
- Operation vectors: rs1=0x00000001 with funct3 000/001/010/011 -> rd = 0x40080400 / 0x04200080 / 0x02004000 / 0x0000A000. For each, ready=wr=1 for exactly one cycle at E+4, and wait is high in E+1..E+3.
- All-ones operand: rs1=0xFFFFFFFF, funct3 000 -> 0xFFFFFFFF; 010 -> 0x1FFFFFFF; 011 -> 0x003FFFFF.
- Unclaimed encodings:
  - opcode 0110011, or funct7=0000001, or funct3=100 -> no wait/ready for 20 cycles.
  - ENABLE_SMALL_SIGMA=0 with funct3=010 -> no wait/ready for 20 cycles.
- Abort and reset mid-operation:
  - Drop valid in T1 -> no ready; wait low next cycle; a new Sigma1 on 0x00000001 then returns 0x04200080.
  - resetn=0 in T2 -> all outputs 0 next cycle.
- Operand stability: change rs1 from 0x00000001 to 0xFFFFFFFF during T0..T2 -> result is still 0x40080400 (funct3 000). Issue two instructions back-to-back -> both complete, ready pulses 5 cycles apart.
